// File: rtl/adder.sv
// adder: pipelined IEEE-754 binary32 add (res = op_1 + op_2), RNE, denormals/zeros/inf/NaN.
// Latency: 3 edges from the en sample to res/val; one operand pair accepted per clock.
// No backpressure: res/val must be consumed when val is high. ADDER_FTZ_EN selects flush-to-zero.
module adder (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] op_1,
  input  logic [31:0] op_2,
  output logic [31:0] res,
  output logic        val
);

  localparam int          LATENCY = 3;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  // Leading-zero count of a 27-bit mantissa; 27 when the value is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1: unpack, classify, order operands so that |A| >= |B|
  // ---------------------------------------------------------------------
  logic [7:0]  exp_1, exp_2;
  logic [22:0] frac_1, frac_2, frac_1_eff, frac_2_eff;
  logic        nan_1, nan_2, inf_1, inf_2, swap;

  assign exp_1  = op_1[30:23];
  assign exp_2  = op_2[30:23];
  assign frac_1 = op_1[22:0];
  assign frac_2 = op_2[22:0];

`ifdef ADDER_FTZ_EN
  // Denormal inputs become signed zeros; the sign bit is left untouched.
  assign frac_1_eff = (exp_1 == 8'd0) ? 23'd0 : frac_1;
  assign frac_2_eff = (exp_2 == 8'd0) ? 23'd0 : frac_2;
`else
  assign frac_1_eff = frac_1;
  assign frac_2_eff = frac_2;
`endif

  assign nan_1 = (exp_1 == 8'hFF) && (frac_1 != 23'd0);
  assign nan_2 = (exp_2 == 8'hFF) && (frac_2 != 23'd0);
  assign inf_1 = (exp_1 == 8'hFF) && (frac_1 == 23'd0);
  assign inf_2 = (exp_2 == 8'hFF) && (frac_2 == 23'd0);

  // Magnitude order of {exp, frac} is valid for denormals as well.
  assign swap = {exp_2, frac_2_eff} > {exp_1, frac_1_eff};

  logic        sign_a_c, sign_b_c;
  logic [7:0]  exp_a_c, exp_b_c, eexp_a_c, eexp_b_c;
  logic [22:0] frac_a_c, frac_b_c;
  logic        spc_c;
  logic [31:0] spc_res_c;

  // Route the larger magnitude to A; denormals get effective exponent 1.
  always_comb begin
    sign_a_c = swap ? op_2[31]   : op_1[31];
    sign_b_c = swap ? op_1[31]   : op_2[31];
    exp_a_c  = swap ? exp_2      : exp_1;
    exp_b_c  = swap ? exp_1      : exp_2;
    frac_a_c = swap ? frac_2_eff : frac_1_eff;
    frac_b_c = swap ? frac_1_eff : frac_2_eff;
    eexp_a_c = (exp_a_c == 8'd0) ? 8'd1 : exp_a_c;
    eexp_b_c = (exp_b_c == 8'd0) ? 8'd1 : exp_b_c;
  end

  // Special-operand result, resolved early and carried down the pipe.
  always_comb begin
    spc_c     = 1'b1;
    spc_res_c = QNAN;
    if (nan_1 || nan_2)                             spc_res_c = QNAN;
    else if (inf_1 && inf_2 && (op_1[31] != op_2[31])) spc_res_c = QNAN;
    else if (inf_1)                                 spc_res_c = {op_1[31], 8'hFF, 23'd0};
    else if (inf_2)                                 spc_res_c = {op_2[31], 8'hFF, 23'd0};
    else                                            spc_c     = 1'b0;
  end

  logic [LATENCY-1:0] vld_sr;
  logic               s1_sign_a, s1_sign_b, s1_spc;
  logic [7:0]         s1_exp_a, s1_diff;
  logic [23:0]        s1_man_a, s1_man_b;
  logic [31:0]        s1_spc_res;

  // Stage-valid shift register and output valid; reset discards in-flight work.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      val    <= 1'b0;
    end else begin
      vld_sr <= {vld_sr[LATENCY-2:0], en};
      val    <= vld_sr[LATENCY-1];
    end
  end

  // Stage 1 register: unpacked, ordered operands.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign_a  <= sign_a_c;
      s1_sign_b  <= sign_b_c;
      s1_exp_a   <= eexp_a_c;
      s1_diff    <= eexp_a_c - eexp_b_c;
      s1_man_a   <= {exp_a_c != 8'd0, frac_a_c};
      s1_man_b   <= {exp_b_c != 8'd0, frac_b_c};
      s1_spc     <= spc_c;
      s1_spc_res <= spc_res_c;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: align B with guard/round/sticky, then add or subtract
  // ---------------------------------------------------------------------
  logic [26:0] a27, b27;
  logic [53:0] b_wide;
  logic [27:0] sum_c;

  assign a27    = {s1_man_a, 3'b000};
  assign b_wide = {s1_man_b, 30'd0} >> s1_diff;

  // Bits shifted past the round position collapse into the sticky bit.
  always_comb begin
    if (s1_diff >= 8'd27) b27 = {26'd0, |s1_man_b};
    else                  b27 = {b_wide[53:28], b_wide[27] | (|b_wide[26:0])};
  end

  // |A| >= |B|, so the difference never goes negative.
  assign sum_c = (s1_sign_a == s1_sign_b) ? ({1'b0, a27} + {1'b0, b27})
                                          : ({1'b0, a27} - {1'b0, b27});

  logic        s2_sign, s2_zsign, s2_spc;
  logic [7:0]  s2_exp;
  logic [27:0] s2_sum;
  logic [31:0] s2_spc_res;

  // Stage 2 register: raw signed-magnitude sum.
  always_ff @(posedge clk) begin
    if (vld_sr[0]) begin
      s2_sign    <= s1_sign_a;
      s2_zsign   <= s1_sign_a & s1_sign_b;
      s2_exp     <= s1_exp_a;
      s2_sum     <= sum_c;
      s2_spc     <= s1_spc;
      s2_spc_res <= s1_spc_res;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3a: normalise (split from rounding across two register ranks)
  // ---------------------------------------------------------------------
  logic [4:0]  lz_c;
  logic [7:0]  lim_c, sh_c;
  logic [26:0] m_c;
  logic [9:0]  e_c;

  assign lz_c  = lzc27(s2_sum[26:0]);
  assign lim_c = s2_exp - 8'd1;
  // Never shift below exponent 1: the result then stays an exact denormal.
  assign sh_c  = ({3'd0, lz_c} < lim_c) ? {3'd0, lz_c} : lim_c;

  // Carry-out shifts right one place; otherwise shift left by the clamped count.
  always_comb begin
    if (s2_sum[27]) begin
      m_c = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
      e_c = {2'd0, s2_exp} + 10'd1;
    end else begin
      m_c = s2_sum[26:0] << sh_c;
      e_c = {2'd0, s2_exp} - {2'd0, sh_c};
    end
  end

  logic        s3_sign, s3_zsign, s3_zero, s3_spc;
  logic [9:0]  s3_exp;
  logic [26:0] s3_man;
  logic [31:0] s3_spc_res;

  // Stage 3a register: normalised mantissa with G/R/S in the low three bits.
  always_ff @(posedge clk) begin
    if (vld_sr[1]) begin
      s3_sign    <= s2_sign;
      s3_zsign   <= s2_zsign;
      s3_zero    <= (s2_sum == 28'd0);
      s3_exp     <= e_c;
      s3_man     <= m_c;
      s3_spc     <= s2_spc;
      s3_spc_res <= s2_spc_res;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3b: round to nearest even, overflow, pack
  // ---------------------------------------------------------------------
  logic        round_up_c;
  logic [24:0] rnd_c;
  logic [9:0]  ef_c;
  logic [22:0] frac_c;
  logic [31:0] pack_c;

  assign round_up_c = s3_man[2] & (s3_man[3] | s3_man[1] | s3_man[0]);
  assign rnd_c      = {1'b0, s3_man[26:3]} + {24'd0, round_up_c};

  // A rounding carry bumps the exponent; a denormal rounding into bit 23 becomes normal.
  always_comb begin
    ef_c   = 10'd0;
    frac_c = rnd_c[22:0];
    if (rnd_c[24]) begin
      ef_c   = s3_exp + 10'd1;
      frac_c = 23'd0;
    end else if (rnd_c[23]) begin
      ef_c   = s3_exp;
    end

    if (s3_spc)                pack_c = s3_spc_res;
    else if (s3_zero)          pack_c = {s3_zsign, 31'd0};
    else if (ef_c >= 10'd255)  pack_c = {s3_sign, 8'hFF, 23'd0};
`ifdef ADDER_FTZ_EN
    else if (ef_c == 10'd0)    pack_c = {s3_sign, 31'd0};
`endif
    else                       pack_c = {s3_sign, ef_c[7:0], frac_c};
  end

  // Output register: updates only with a valid result, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset)                  res <= 32'h0;
    else if (vld_sr[LATENCY-1]) res <= pack_c;
  end

endmodule

// File: tb/tb_adder.sv
// tb_adder: directed vectors for the binary32 adder, streamed back-to-back,
// plus bubble and reset-with-ops-in-flight sequences. Default build (no FTZ).
module tb_adder;

  logic        clk = 1'b0;
  logic        reset, en, val;
  logic [31:0] op_1, op_2, res;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;

  adder dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .op_1 (op_1),
    .op_2 (op_2),
    .res  (res),
    .val  (val)
  );

  always #5 clk = ~clk;

  localparam int N = 22;
  localparam logic [31:0] VA [N] = '{
    32'h4151EC0C, 32'h3F800000, 32'h3F800000, 32'h00000008, 32'h00000003, 32'h00800000,
    32'h00800000, 32'h00800001, 32'h7F800000, 32'h7F800001, 32'h7F800000, 32'h7F7FFFFF,
    32'h3F800000, 32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800001, 32'h3F800000,
    32'h3F800000, 32'h7F7FFFFF, 32'h00000001, 32'hFF800000};
  localparam logic [31:0] VB [N] = '{
    32'h4143C0B8, 32'h3F800000, 32'hC0000000, 32'h00000003, 32'h007FFFFF, 32'h00000002,
    32'h80000002, 32'h80800000, 32'hFF800000, 32'h00000001, 32'h00000001, 32'h7F7FFFFF,
    32'hBF800000, 32'h80000000, 32'h80000000, 32'h33800000, 32'h33800000, 32'h33800001,
    32'hB3800000, 32'h73000000, 32'hFF800000, 32'h7FC00001};
  // Hand-derived RNE sums (e.g. 13.1201 + 12.2346 -> 0x41CAD662, 1 + 2^-24 tie -> 1).
  localparam logic [31:0] VE [N] = '{
    32'h41CAD662, 32'h40000000, 32'hBF800000, 32'h0000000B, 32'h00800002, 32'h00800002,
    32'h007FFFFE, 32'h00000001, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h7F800000,
    32'h00000000, 32'h80000000, 32'h00000000, 32'h3F800000, 32'h3F800002, 32'h3F800001,
    32'h3F7FFFFF, 32'h7F800000, 32'hFF800000, 32'h7FC00000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    op_1  = 32'h0;
    op_2  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_val", {31'd0, val}, 32'd0);
    check("reset_res", res, 32'h0);
    reset = 1'b0;

    // Back-to-back stream: vector c issued at edge c, checked after edge c+3.
    for (int c = 0; c < N + 3; c++) begin
      if (c < N) begin
        en   = 1'b1;
        op_1 = VA[c];
        op_2 = VB[c];
      end else begin
        en = 1'b0;
      end
      step();
      if (c >= 3) begin
        check($sformatf("stream_val%0d", c - 3), {31'd0, val}, 32'd1);
        check($sformatf("stream_res%0d", c - 3), res, VE[c - 3]);
      end
    end

    // en pattern 1,0,1 -> val pattern 1,0,1; res holds through the bubble.
    for (int c = 0; c < 6; c++) begin
      en   = (c == 0) || (c == 2);
      op_1 = (c == 2) ? VA[2] : VA[1];
      op_2 = (c == 2) ? VB[2] : VB[1];
      step();
      if (c == 3) begin
        check("bubble_val0", {31'd0, val}, 32'd1);
        check("bubble_res0", res, 32'h40000000);
      end else if (c == 4) begin
        check("bubble_val1", {31'd0, val}, 32'd0);
        check("bubble_hold", res, 32'h40000000);
      end else if (c == 5) begin
        check("bubble_val2", {31'd0, val}, 32'd1);
        check("bubble_res2", res, 32'hBF800000);
      end
    end

    // Reset with two operations in flight, en still high on the reset edge.
    en = 1'b1; op_1 = VA[0]; op_2 = VB[0];
    step();
    op_1 = VA[1]; op_2 = VB[1];
    step();
    reset = 1'b1; op_1 = VA[2]; op_2 = VB[2];
    step();
    check("inflight_rst_val", {31'd0, val}, 32'd0);
    check("inflight_rst_res", res, 32'h0);
    reset = 1'b0;
    en    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("no_stale%0d", c), {31'd0, val}, 32'd0);
    end

    // Fresh operation after reset release.
    en = 1'b1; op_1 = VA[3]; op_2 = VB[3];
    step();
    en = 1'b0;
    step();
    step();
    check("post_rst_early", {31'd0, val}, 32'd0);
    step();
    check("post_rst_val", {31'd0, val}, 32'd1);
    check("post_rst_res", res, 32'h0000000B);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
